mdio_arbiter: RTL

- Shares the single MDIO management controller (the frame generator that drives MDIO_OUT/MDIO_OE toward the PHY-side receptor) among NREQ independent requesters.
- Each requester presents a full 32-bit MDIO frame word. The arbiter selects one requester round-robin, validates its frame and launches it on the controller. It then waits for MDIO_DONE and returns read data plus a per-requester done/error pulse.
- Sits between management software/register blocks and the MDIO controller, in the MDC clock domain.

---
 rtl/mdio_pkg.sv | 32 +++
 rtl/mdio_arbiter_if.sv | 31 +++
 rtl/mdio_rr_pick.sv | 33 +++
 rtl/mdio_arbiter.sv | 132 +++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// mdio_pkg: shared MDIO frame layout, field codes and arbiter state encoding.
// Imported by the MDIO arbiter and any other block that builds or parses
// 32-bit clause-22 management frames.
package mdio_pkg;

  // Frame word layout, MSB first: ST OP PHYAD REGAD TA DATA.
  typedef struct packed {
    logic [1:0]  st;     // [31:30]
    logic [1:0]  op;     // [29:28]
    logic [4:0]  phyad;  // [27:23]
    logic [4:0]  regad;  // [22:18]
    logic [1:0]  ta;     // [17:16]
    logic [15:0] data;   // [15:0]
  } mdio_frame_t;

  localparam logic [1:0] ST_START = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_CHECK,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_COMPLETE
  } arb_state_t;

  function automatic logic frame_ok(input mdio_frame_t f);
    return (f.st == ST_START) && ((f.op == OP_WRITE) || (f.op == OP_READ));
  endfunction

endpackage

// File: rtl/mdio_arbiter_if.sv
// mdio_arbiter_if: requester + controller signal bundle for mdio_arbiter.
//   REQ/REQ_FRAME      : per-requester request level and 32-bit frame word
//   GNT/REQ_DONE       : one-hot owner and one-hot completion pulse
//   REQ_ERR/REQ_RD_DATA: completion status and read data
//   MDIO_START/T_DATA  : launch strobe and frame word to the MDIO controller
//   MDIO_DONE/RD_DATA  : controller completion pulse and read data
// slave modport: the arbiter. master modport: requesters + controller side.
interface mdio_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]      REQ;
  logic [32*NREQ-1:0]   REQ_FRAME;
  logic [NREQ-1:0]      GNT;
  logic [NREQ-1:0]      REQ_DONE;
  logic                 REQ_ERR;
  logic [15:0]          REQ_RD_DATA;
  logic                 MDIO_START;
  logic [31:0]          T_DATA;
  logic                 MDIO_DONE;
  logic [15:0]          RD_DATA;

  modport slave (
    input  REQ, REQ_FRAME, MDIO_DONE, RD_DATA,
    output GNT, REQ_DONE, REQ_ERR, REQ_RD_DATA, MDIO_START, T_DATA
  );

  modport master (
    output REQ, REQ_FRAME, MDIO_DONE, RD_DATA,
    input  GNT, REQ_DONE, REQ_ERR, REQ_RD_DATA, MDIO_START, T_DATA
  );
endinterface

// File: rtl/mdio_rr_pick.sv
// mdio_rr_pick: combinational round-robin priority selector.
//   req : request vector
//   ptr : index holding highest priority this round
//   gnt : one-hot winner (first set bit from ptr upward, wrapping)
//   idx : binary index of the winner
//   any : at least one request present
module mdio_rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);
  localparam int unsigned PW = $clog2(N);

  always_comb begin
    int unsigned k;
    k   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      k = (32'(ptr) + i) % N;
      if (!any && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = PW'(k);
      end
    end
  end
endmodule

// File: rtl/mdio_arbiter.sv
// mdio_arbiter: round-robin sharing of one MDIO controller among NREQ
// requesters. A granted frame is checked (ST=01, OP=write/read), launched
// with a one-cycle MDIO_START, and completed with a one-hot REQ_DONE pulse
// carrying REQ_ERR and, for reads, REQ_RD_DATA.
//   MDC   : clock, rising edge
//   RESET : asynchronous, active-high
//   bus   : mdio_arbiter_if.slave (requester and controller signals)
// Optional: define MDIO_ARB_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYC cycles (REQ_ERR=1, REQ_RD_DATA=16'hFFFF).
module mdio_arbiter
  import mdio_pkg::*;
#(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned TIMEOUT_CYC = 96
) (
  input logic          MDC,
  input logic          RESET,
  mdio_arbiter_if.slave bus
);
  localparam int unsigned PW = $clog2(NREQ);

  // Empty marker block: elaboration names it if parameters leave the
  // supported range (2..8 requesters, 8-bit timeout counter).
  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_param_out_of_range
  end

  arb_state_t      state;
  logic [NREQ-1:0] gnt_q;
  logic [PW-1:0]   gidx_q;
  logic [PW-1:0]   ptr_q;
  mdio_frame_t     t_data_q;
  logic            start_q;
  logic [NREQ-1:0] done_q;
  logic            err_q;
  logic [15:0]     rd_data_q;
`ifdef MDIO_ARB_TIMEOUT_EN
  logic [7:0]      wait_cnt;
`endif

  logic [NREQ-1:0] pick_gnt;
  logic [PW-1:0]   pick_idx;
  logic            pick_any;

  mdio_rr_pick #(.N(NREQ)) u_pick (
    .req (bus.REQ),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // REQ_DONE is registered on the transition into COMPLETE so it is visible
  // during the COMPLETE cycle, one edge after MDIO_DONE (or after CHECK).
  always_ff @(posedge MDC or posedge RESET) begin
    if (RESET) begin
      state     <= ARB_IDLE;
      gnt_q     <= '0;
      gidx_q    <= '0;
      ptr_q     <= '0;
      t_data_q  <= '0;
      start_q   <= 1'b0;
      done_q    <= '0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
`ifdef MDIO_ARB_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      start_q <= 1'b0;
      done_q  <= '0;
      case (state)
        ARB_IDLE: begin
          if (pick_any) begin
            gnt_q    <= pick_gnt;
            gidx_q   <= pick_idx;
            t_data_q <= mdio_frame_t'(bus.REQ_FRAME[32*pick_idx +: 32]);
            state    <= ARB_CHECK;
          end
        end
        ARB_CHECK: begin
          if (frame_ok(t_data_q)) begin
            state <= ARB_ISSUE;
          end else begin
            err_q  <= 1'b1;
            done_q <= gnt_q;
            state  <= ARB_COMPLETE;
          end
        end
        ARB_ISSUE: begin
          start_q <= 1'b1;
`ifdef MDIO_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state   <= ARB_WAIT;
        end
        ARB_WAIT: begin
          // start_q is high in the first WAIT cycle; a DONE coincident with
          // the strobe cannot belong to this transaction.
          if (bus.MDIO_DONE && !start_q) begin
            if (t_data_q.op == OP_READ) rd_data_q <= bus.RD_DATA;
            err_q  <= 1'b0;
            done_q <= gnt_q;
            state  <= ARB_COMPLETE;
          end
`ifdef MDIO_ARB_TIMEOUT_EN
          else if (wait_cnt == 8'(TIMEOUT_CYC - 1)) begin
            err_q     <= 1'b1;
            rd_data_q <= 16'hFFFF;
            done_q    <= gnt_q;
            state     <= ARB_COMPLETE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end
        ARB_COMPLETE: begin
          gnt_q <= '0;
          ptr_q <= (gidx_q == PW'(NREQ - 1)) ? '0 : gidx_q + PW'(1);
          state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign bus.GNT         = gnt_q;
  assign bus.REQ_DONE    = done_q;
  assign bus.REQ_ERR     = err_q;
  assign bus.REQ_RD_DATA = rd_data_q;
  assign bus.MDIO_START  = start_q;
  assign bus.T_DATA      = t_data_q;
endmodule
